// File: rtl/i2c_passthru_infilter_mc_pkg.sv
// Shared definitions for the multi-channel i2c passthru input deglitch filter.
package i2c_passthru_infilter_mc_pkg;

    // I2C channel index constants
    localparam int CH_SDA = 0;
    localparam int CH_SCL = 1;

    // Default hysteresis thresholds (in clocks) for common bus/clock combinations
    localparam logic [3:0] THR_100K_16M = 4'd4;
    localparam logic [3:0] THR_400K_16M = 4'd2;
    localparam logic [3:0] THR_100K_66M = 4'd15;
    localparam logic [3:0] THR_400K_66M = 4'd8;

    // Edge decision produced by a channel in a given cycle
    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_e;

    // A glitch is a mismatch that went away without the filter toggling
    function automatic logic is_glitch(input logic mis_prev, input logic mis_now,
                                       input logic tog_prev);
        return mis_prev & ~mis_now & ~tog_prev;
    endfunction

endpackage

// File: rtl/i2c_passthru_infilter_ch.sv
// One filter channel: optional 2FF sync, leaky hysteresis counter,
// registered edge strobes and a saturating rejected-glitch counter.
module i2c_passthru_infilter_ch
    import i2c_passthru_infilter_mc_pkg::*;
#(
    parameter int EN_2FF_SYNC = 1,
    parameter int CNT_W       = 4,
    parameter bit RST_VAL     = 1'b1,
    parameter int GLT_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in,
    input  logic [CNT_W-1:0] i_thr_fall,
    input  logic [CNT_W-1:0] i_thr_rise,
    input  logic             i_glt_clr,
    output logic             o_out,
    output logic             o_rise,
    output logic             o_fall,
    output logic [GLT_W-1:0] o_glt_cnt
);

    logic             w_s;
    logic             w_mis;
    logic             w_tog;
    logic [CNT_W-1:0] w_thr;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [GLT_W-1:0] w_glt_nxt;
    edge_e            w_edge;

    logic             r_out;
    logic             r_rise;
    logic             r_fall;
    logic             r_mis_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [GLT_W-1:0] r_glt;

    if (EN_2FF_SYNC != 0) begin : g_sync
        logic r_sync1;
        logic r_sync2;
        // Two-flop synchronizer for the asynchronous pad input
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_sync1 <= RST_VAL;
                r_sync2 <= RST_VAL;
            end else begin
                r_sync1 <= i_in;
                r_sync2 <= r_sync1;
            end
        end
        assign w_s = r_sync2;
    end else begin : g_bypass
        assign w_s = i_in;
    end

    // Falling threshold applies while the output is high, rising while low
    assign w_mis = w_s ^ r_out;
    assign w_thr = r_out ? i_thr_fall : i_thr_rise;
    assign w_tog = w_mis & (r_cnt >= w_thr);

    // Next-state for the leaky counter, edge decision and glitch counter
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_edge    = EDGE_NONE;
        w_glt_nxt = r_glt;
        if (w_tog) begin
            w_cnt_nxt = {CNT_W{1'b0}};
            w_edge    = w_s ? EDGE_RISE : EDGE_FALL;
        end else if (w_mis) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (r_cnt != {CNT_W{1'b0}}) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
        // Clear wins over a same-cycle glitch event
        if (i_glt_clr) begin
            w_glt_nxt = {GLT_W{1'b0}};
        end else if (is_glitch(r_mis_prev, w_mis, r_rise | r_fall) &&
                     (r_glt != {GLT_W{1'b1}})) begin
            w_glt_nxt = r_glt + GLT_W'(1);
        end else begin
            w_glt_nxt = r_glt;
        end
    end

    // Filter state, strobes and glitch history registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out      <= RST_VAL;
            r_cnt      <= {CNT_W{1'b0}};
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_mis_prev <= 1'b0;
            r_glt      <= {GLT_W{1'b0}};
        end else begin
            r_out      <= w_tog ? w_s : r_out;
            r_cnt      <= w_cnt_nxt;
            r_rise     <= (w_edge == EDGE_RISE);
            r_fall     <= (w_edge == EDGE_FALL);
            r_mis_prev <= w_mis;
            r_glt      <= w_glt_nxt;
        end
    end

    assign o_out     = r_out;
    assign o_rise    = r_rise;
    assign o_fall    = r_fall;
    assign o_glt_cnt = r_glt;

endmodule

// File: rtl/i2c_passthru_infilter_mc.sv
// Multi-channel deglitch filter for the i2c passthru input pins:
// one independent filter channel per pin plus bus packing.
module i2c_passthru_infilter_mc
    import i2c_passthru_infilter_mc_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int EN_2FF_SYNC = 1,
    parameter int CNT_W       = 4,
    parameter bit RST_VAL     = 1'b1,
    parameter int GLT_W       = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_CH-1:0]       i_in,
    input  logic [NUM_CH*CNT_W-1:0] i_thr_fall,
    input  logic [NUM_CH*CNT_W-1:0] i_thr_rise,
    input  logic [NUM_CH-1:0]       i_glt_clr,
    output logic [NUM_CH-1:0]       o_out,
    output logic [NUM_CH-1:0]       o_rise,
    output logic [NUM_CH-1:0]       o_fall,
    output logic [NUM_CH*GLT_W-1:0] o_glt_cnt
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        i2c_passthru_infilter_ch #(
            .EN_2FF_SYNC (EN_2FF_SYNC),
            .CNT_W       (CNT_W),
            .RST_VAL     (RST_VAL),
            .GLT_W       (GLT_W)
        ) u_ch (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_in       (i_in[c]),
            .i_thr_fall (i_thr_fall[c*CNT_W +: CNT_W]),
            .i_thr_rise (i_thr_rise[c*CNT_W +: CNT_W]),
            .i_glt_clr  (i_glt_clr[c]),
            .o_out      (o_out[c]),
            .o_rise     (o_rise[c]),
            .o_fall     (o_fall[c]),
            .o_glt_cnt  (o_glt_cnt[c*GLT_W +: GLT_W])
        );
    end

endmodule
